// File: rtl/store_check_monitor.sv
// store_check_monitor
//
// Self-check monitor for the pipeline core's data-memory store port. It holds a
// programmable table of expected store data indexed by word address (entry i lives
// at BASE_ADDR + 4*i). Every store seen while a run is active is classified against
// that table. The monitor then reports the pass/fail counts, the first failing store
// and a final verdict. A cycle timeout ends a run that never completes.
//
// Ports
//   clk_i              single clock, rising edge
//   rst_ni             asynchronous active-low reset
//   exp_we_i           expected-table write strobe (accepted only while idle)
//   exp_idx_i          table index to write
//   exp_data_i         expected store data
//   start_i            one-cycle pulse that begins a check run
//   memwrite_i         core store strobe
//   dataadr_i          core store byte address
//   writedata_i        core store data
//   done_o             run finished, held until the next start
//   pass_o             verdict, meaningful while done_o is set
//   pass_cnt_o         matched stores (saturating)
//   fail_cnt_o         failed or illegal stores (saturating)
//   timeout_o          run ended by the cycle timeout
//   first_fail_addr_o  address of the first failing store of the run
//   first_fail_data_o  data of the first failing store of the run

module store_check_monitor #(
    parameter int unsigned NUM_CHECKS     = 9,
    parameter int unsigned BASE_ADDR      = 200,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        exp_we_i,
    input  logic [4:0]  exp_idx_i,
    input  logic [31:0] exp_data_i,
    input  logic        start_i,
    input  logic        memwrite_i,
    input  logic [31:0] dataadr_i,
    input  logic [31:0] writedata_i,
    output logic        done_o,
    output logic        pass_o,
    output logic [5:0]  pass_cnt_o,
    output logic [5:0]  fail_cnt_o,
    output logic        timeout_o,
    output logic [31:0] first_fail_addr_o,
    output logic [31:0] first_fail_data_o
);

    localparam int unsigned IdxW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
    localparam int unsigned CycW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CycW-1:0] CycLast    = CycW'(TIMEOUT_CYCLES - 1);
    localparam logic [5:0]      CntMax     = 6'd63;
    localparam logic [5:0]      NumChecks6 = 6'(NUM_CHECKS);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                 state_q, state_d;
    logic [NUM_CHECKS-1:0]  seen_q, seen_d;
    logic [5:0]             pass_cnt_q, pass_cnt_d;
    logic [5:0]             fail_cnt_q, fail_cnt_d;
    logic [CycW-1:0]        cyc_q, cyc_d;
    logic [31:0]            ff_addr_q, ff_addr_d;
    logic [31:0]            ff_data_q, ff_data_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic                   timeout_q, timeout_d;

    // Expected table: deliberately not reset, contents are defined only once written.
    logic [31:0] exp_tbl_q [NUM_CHECKS];

    // Store classification. The subtraction wraps, so addresses below BASE_ADDR
    // become huge word indices and fall out of range naturally.
    logic [31:0]     word_idx;
    logic            addr_legal;
    logic [IdxW-1:0] tbl_idx;
    logic            exp_idx_ok;

    assign word_idx   = (dataadr_i - BASE_ADDR) >> 2;
    assign addr_legal = (dataadr_i[1:0] == 2'b00) && (word_idx < 32'(NUM_CHECKS));
    assign tbl_idx    = addr_legal ? word_idx[IdxW-1:0] : '0;
    assign exp_idx_ok = ({27'b0, exp_idx_i} < 32'(NUM_CHECKS));

    always_ff @(posedge clk_i) begin
        if (state_q == StIdle && exp_we_i && exp_idx_ok) begin
            exp_tbl_q[exp_idx_i[IdxW-1:0]] <= exp_data_i;
        end
    end

    always_comb begin
        logic store_fail;
        logic start_run;

        state_d    = state_q;
        seen_d     = seen_q;
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        cyc_d      = cyc_q;
        ff_addr_d  = ff_addr_q;
        ff_data_d  = ff_data_q;
        done_d     = done_q;
        pass_d     = pass_q;
        timeout_d  = timeout_q;
        store_fail = 1'b0;
        start_run  = 1'b0;

        unique case (state_q)
            StIdle: begin
                start_run = start_i;
            end
            StRun: begin
                cyc_d = (&cyc_q) ? cyc_q : cyc_q + 1'b1;

                if (memwrite_i) begin
                    if (addr_legal && !seen_q[tbl_idx]) begin
                        seen_d[tbl_idx] = 1'b1;
                        if (writedata_i == exp_tbl_q[tbl_idx]) begin
                            if (pass_cnt_q != CntMax) begin
                                pass_cnt_d = pass_cnt_q + 1'b1;
                            end
                        end else begin
                            store_fail = 1'b1;
                        end
                    end else begin
                        store_fail = 1'b1;
                    end
                end

                if (store_fail) begin
                    if (fail_cnt_q != CntMax) begin
                        fail_cnt_d = fail_cnt_q + 1'b1;
                    end
                    // Counters are cleared at start and never wrap back to zero, so a
                    // zero count means no failure has been recorded yet in this run.
                    if (fail_cnt_q == 6'd0) begin
                        ff_addr_d = dataadr_i;
                        ff_data_d = writedata_i;
                    end
                end

                // Completion looks at the registered bitmap, so the store that fills
                // it is counted one edge before DONE is entered.
                if (&seen_q) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    pass_d  = (fail_cnt_d == 6'd0) && (pass_cnt_d == NumChecks6);
                end else if (cyc_q == CycLast) begin
                    state_d   = StDone;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end
            end
            StDone: begin
                start_run = start_i;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A start edge only clears state; any store on that same edge is not checked.
        if (start_run) begin
            state_d    = StRun;
            seen_d     = '0;
            pass_cnt_d = '0;
            fail_cnt_d = '0;
            cyc_d      = '0;
            ff_addr_d  = '0;
            ff_data_d  = '0;
            done_d     = 1'b0;
            pass_d     = 1'b0;
            timeout_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            seen_q     <= '0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            cyc_q      <= '0;
            ff_addr_q  <= '0;
            ff_data_q  <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            seen_q     <= seen_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            cyc_q      <= cyc_d;
            ff_addr_q  <= ff_addr_d;
            ff_data_q  <= ff_data_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            timeout_q  <= timeout_d;
        end
    end

    assign done_o            = done_q;
    assign pass_o            = pass_q;
    assign pass_cnt_o        = pass_cnt_q;
    assign fail_cnt_o        = fail_cnt_q;
    assign timeout_o         = timeout_q;
    assign first_fail_addr_o = ff_addr_q;
    assign first_fail_data_o = ff_data_q;

endmodule

// File: tb/tb_store_check_monitor.sv
// Directed bench for store_check_monitor. Each driven store pushes its expected
// counter / first-fail values into a scoreboard queue; they are popped and compared
// one edge later, when the registered outputs reflect that store.

module tb_store_check_monitor;

    logic        clk;
    logic        rst_n;
    logic        exp_we;
    logic [4:0]  exp_idx;
    logic [31:0] exp_data;
    logic        start;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        done;
    logic        pass;
    logic [5:0]  pass_cnt;
    logic [5:0]  fail_cnt;
    logic        timeout;
    logic [31:0] first_fail_addr;
    logic [31:0] first_fail_data;

    store_check_monitor #(
        .NUM_CHECKS    (9),
        .BASE_ADDR     (200),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .exp_we_i         (exp_we),
        .exp_idx_i        (exp_idx),
        .exp_data_i       (exp_data),
        .start_i          (start),
        .memwrite_i       (memwrite),
        .dataadr_i        (dataadr),
        .writedata_i      (writedata),
        .done_o           (done),
        .pass_o           (pass),
        .pass_cnt_o       (pass_cnt),
        .fail_cnt_o       (fail_cnt),
        .timeout_o        (timeout),
        .first_fail_addr_o(first_fail_addr),
        .first_fail_data_o(first_fail_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  pc;
        logic [5:0]  fc;
        logic [31:0] fa;
        logic [31:0] fd;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    logic [31:0] tbl [9];

    // Reference model state (driven from the specification's store rules).
    logic        m_active;
    logic [8:0]  m_seen;
    logic [5:0]  m_pc;
    logic [5:0]  m_fc;
    logic [31:0] m_fa;
    logic [31:0] m_fd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        exp_we   = 1'b0;
        start    = 1'b0;
        memwrite = 1'b0;
        tick();
    endtask

    task automatic load_table();
        for (int i = 0; i < 9; i++) begin
            exp_we   = 1'b1;
            exp_idx  = 5'(i);
            exp_data = tbl[i];
            tick();
        end
        // Out-of-range index must be dropped.
        exp_idx  = 5'd9;
        exp_data = 32'hDEAD_BEEF;
        tick();
        exp_we = 1'b0;
    endtask

    task automatic do_start(input logic with_store);
        start     = 1'b1;
        memwrite  = with_store;
        dataadr   = 32'd236;
        writedata = 32'h0;
        tick();
        start    = 1'b0;
        memwrite = 1'b0;
        m_active = 1'b1;
        m_seen   = '0;
        m_pc     = '0;
        m_fc     = '0;
        m_fa     = '0;
        m_fd     = '0;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input string tag);
        logic [31:0] idx;
        logic        bad;
        exp_t        e;
        memwrite  = 1'b1;
        dataadr   = addr;
        writedata = data;
        if (m_active) begin
            idx = (addr - 32'd200) >> 2;
            bad = 1'b0;
            if (addr[1:0] == 2'b00 && idx < 32'd9) begin
                if (!m_seen[idx]) begin
                    m_seen[idx] = 1'b1;
                    if (data == tbl[idx]) m_pc++;
                    else bad = 1'b1;
                end else begin
                    bad = 1'b1;
                end
            end else begin
                bad = 1'b1;
            end
            if (bad) begin
                if (m_fc == 0) begin
                    m_fa = addr;
                    m_fd = data;
                end
                m_fc++;
            end
        end
        e.pc = m_pc;
        e.fc = m_fc;
        e.fa = m_fa;
        e.fd = m_fd;
        sb_q.push_back(e);
        tick();
        memwrite = 1'b0;
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, " pass_cnt"}, 32'(pass_cnt), 32'(e.pc));
            check({tag, " fail_cnt"}, 32'(fail_cnt), 32'(e.fc));
            check({tag, " first_fail_addr"}, first_fail_addr, e.fa);
            check({tag, " first_fail_data"}, first_fail_data, e.fd);
        end
    endtask

    task automatic all_match(input string tag);
        for (int i = 0; i < 9; i++) begin
            store(32'd200 + 32'(4 * i), tbl[i], tag);
        end
    endtask

    task automatic check_outs(input string tag, input logic d, input logic p,
                              input logic [5:0] pc, input logic [5:0] fc, input logic t);
        check({tag, " done"}, 32'(done), 32'(d));
        check({tag, " pass"}, 32'(pass), 32'(p));
        check({tag, " pass_cnt"}, 32'(pass_cnt), 32'(pc));
        check({tag, " fail_cnt"}, 32'(fail_cnt), 32'(fc));
        check({tag, " timeout"}, 32'(timeout), 32'(t));
    endtask

    initial begin
        tbl[0] = 32'h0000_0300;
        tbl[1] = 32'h0000_0001;
        tbl[2] = 32'h0000_0001;
        tbl[3] = 32'h0000_0096;
        tbl[4] = 32'h0000_0244;
        tbl[5] = 32'hFFFF_FF9B;
        tbl[6] = 32'h0000_1600;
        tbl[7] = 32'h0000_0006;
        tbl[8] = 32'hFFFF_FFF9;

        m_active  = 1'b0;
        m_seen    = '0;
        m_pc      = '0;
        m_fc      = '0;
        m_fa      = '0;
        m_fd      = '0;
        rst_n     = 1'b0;
        exp_we    = 1'b0;
        exp_idx   = '0;
        exp_data  = '0;
        start     = 1'b0;
        memwrite  = 1'b0;
        dataadr   = '0;
        writedata = '0;

        // Reset state.
        tick();
        tick();
        check_outs("reset", 1'b0, 1'b0, 6'd0, 6'd0, 1'b0);
        check("reset first_fail_addr", first_fail_addr, 32'd0);
        rst_n = 1'b1;
        tick();

        // Stores while idle are ignored.
        store(32'd200, 32'h300, "idle store");

        // All match.
        load_table();
        do_start(1'b0);
        check_outs("start", 1'b0, 1'b0, 6'd0, 6'd0, 1'b0);
        all_match("allmatch");
        check("allmatch done before extra edge", 32'(done), 32'd0);
        idle_cycle();
        m_active = 1'b0;
        check_outs("allmatch end", 1'b1, 1'b1, 6'd9, 6'd0, 1'b0);

        // After DONE: stores and table writes are ignored.
        store(32'd236, 32'h1, "done store");
        exp_we   = 1'b1;
        exp_idx  = 5'd0;
        exp_data = 32'h1234_5678;
        tick();
        exp_we = 1'b0;
        check_outs("done ignored", 1'b1, 1'b1, 6'd9, 6'd0, 1'b0);

        // Mismatch on entry 7 (restart from DONE).
        do_start(1'b0);
        check_outs("restart", 1'b0, 1'b0, 6'd0, 6'd0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            if (i == 7) store(32'd228, 32'h5, "mismatch");
            else store(32'd200 + 32'(4 * i), tbl[i], "mismatch");
        end
        idle_cycle();
        m_active = 1'b0;
        check_outs("mismatch end", 1'b1, 1'b0, 6'd8, 6'd1, 1'b0);
        check("mismatch first_fail_addr", first_fail_addr, 32'd228);
        check("mismatch first_fail_data", first_fail_data, 32'd5);

        // Illegal addresses: past the end, below base, misaligned.
        do_start(1'b0);
        store(32'd236, 32'hAA, "illegal");
        store(32'd198, 32'hBB, "illegal");
        store(32'd202, 32'hCC, "illegal");
        all_match("illegal");
        idle_cycle();
        m_active = 1'b0;
        check_outs("illegal end", 1'b1, 1'b0, 6'd9, 6'd3, 1'b0);
        check("illegal first_fail_addr", first_fail_addr, 32'd236);

        // Duplicate, ignored start during RUN, then timeout on the 64th RUN edge.
        do_start(1'b0);
        store(32'd200, 32'h300, "dup");
        store(32'd200, 32'h300, "dup");
        start = 1'b1;
        tick();
        start = 1'b0;
        check_outs("start in run", 1'b0, 1'b0, 6'd1, 6'd1, 1'b0);
        repeat (60) idle_cycle();
        check_outs("edge 63", 1'b0, 1'b0, 6'd1, 6'd1, 1'b0);
        idle_cycle();
        m_active = 1'b0;
        check_outs("timeout", 1'b1, 1'b0, 6'd1, 6'd1, 1'b1);

        // Reset mid-run after four stores (one of them failing).
        do_start(1'b0);
        store(32'd200, tbl[0], "prereset");
        store(32'd204, tbl[1], "prereset");
        store(32'd208, tbl[2], "prereset");
        store(32'd212, 32'h77, "prereset");
        #2;
        rst_n = 1'b0;
        #1;
        m_active = 1'b0;
        check_outs("midreset", 1'b0, 1'b0, 6'd0, 6'd0, 1'b0);
        check("midreset first_fail_addr", first_fail_addr, 32'd0);
        check("midreset first_fail_data", first_fail_data, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Reload, start with a simultaneous illegal store (must not be checked).
        load_table();
        do_start(1'b1);
        check_outs("start with store", 1'b0, 1'b0, 6'd0, 6'd0, 1'b0);
        all_match("after reset");
        idle_cycle();
        m_active = 1'b0;
        check_outs("after reset end", 1'b1, 1'b1, 6'd9, 6'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_check_monitor.md
# store_check_monitor

Synthesizable self-check block on the pipeline core's data-memory store port (memwrite, dataadr, writedata) for on-chip/FPGA regression of RV32I instruction-group test programs. It runs alongside `RISC_V_pipeline_top` and consumes its store bus directly. Each store is checked against a programmable expected-value table indexed by word address. The block then reports pass/fail counts, first-failure details and a final verdict, with a cycle timeout.

## Interface
- `NUM_CHECKS`, default 9: number of expected stores (table depth, ≤ 32).
- `BASE_ADDR`, default 200: byte address of table entry 0; entry i is at `BASE_ADDR + 4*i`.
- `TIMEOUT_CYCLES`, default 64: maximum RUN cycles before forced finish.
- `clk`, in, 1: single clock; all state updates on rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `exp_we`, in, 1: expected-table write strobe (honoured only in IDLE).
- `exp_idx`, in, 5: table index to write.
- `exp_data`, in, 32: expected store data.
- `start`, in, 1: one-cycle pulse; begins a check run.
- `memwrite`, in, 1: core store strobe.
- `dataadr`, in, 32: core store byte address.
- `writedata`, in, 32: core store data.
- `done`, out, 1: run finished (level, held until next `start`).
- `pass`, out, 1: valid when `done`; 1 only if every entry was matched exactly once with no errors.
- `pass_cnt`, out, 6: matched stores.
- `fail_cnt`, out, 6: failed or illegal stores.
- `timeout`, out, 1: run ended by timeout.
- `first_fail_addr`, out, 32: `dataadr` of the first failing store.
- `first_fail_data`, out, 32: `writedata` of the first failing store.

## Operation
- States are IDLE, RUN, DONE.
- IDLE:
  - `exp_we` writes `exp_data` into entry `exp_idx`; writes with `exp_idx ≥ NUM_CHECKS` are ignored.
  - `memwrite` is ignored.
  - `start` moves to RUN. The same edge clears the counters, `seen` bitmap, cycle counter, first-fail registers, `done`, `pass` and `timeout`.
- RUN: on each cycle with `memwrite`=1, compute idx = (dataadr − BASE_ADDR) >> 2 and classify the store:
  - Legal and matching: address aligned (bits[1:0]=0), within BASE_ADDR..BASE_ADDR+4*(NUM_CHECKS−1), `seen[idx]`=0, and `writedata` === entry. Action: `pass_cnt`+1, set `seen[idx]`.
  - Data mismatch on a legal, unseen address: `fail_cnt`+1, set `seen[idx]`.
  - Duplicate store to a seen index: `fail_cnt`+1.
  - Out-of-range or misaligned address: `fail_cnt`+1.
  - Any failure: if it is the first failure of the run, latch `first_fail_addr`/`first_fail_data`.
- Subtraction is 32-bit unsigned. An address below BASE_ADDR wraps to a large value and is therefore out of range.
- Cycle counter increments every RUN cycle and saturates.
- RUN → DONE when all `seen` bits are set, or when the cycle counter reaches TIMEOUT_CYCLES−1 (which also sets `timeout`).
- DONE:
  - `done`=1.
  - `pass` = (fail_cnt==0) & (pass_cnt==NUM_CHECKS) & ~timeout.
  - Later stores are ignored and counters freeze.
  - `start` re-enters RUN; `exp_we` is ignored until reset.
- `start` during RUN is ignored.
- Counters saturate at 63.

## Timing
- Reset state: IDLE; `done`, `pass`, `timeout` = 0; `pass_cnt`, `fail_cnt` = 0; `first_fail_*` = 0; `seen` = 0.
- Expected table is not reset (contents undefined until written).
- Reset mid-run aborts immediately and returns to IDLE with the reset values above.
- Store sampled on rising edge N; counters and first-fail registers update at edge N, visible after it (1-cycle latency).
- The store that sets the last `seen` bit is counted at edge N; state is DONE and `done`=1 after edge N+1.
- Outputs are registered; no combinational path from inputs to outputs.
- If the final store and the timeout land on the same edge, the store is counted and `timeout` is set, so `pass`=0.
- A `start` edge with `memwrite`=1 does not check that store; checking begins the next cycle.

## Test plan
- **All match:** load entries 300, 1, 1, 96, 244, FFFFFF9B, 1600, 6, FFFFFFF9 at BASE 200; pulse `start`; drive 9 matching stores to 200..232 → `done`=1, `pass`=1, `pass_cnt`=9, `fail_cnt`=0, `timeout`=0.
- **Mismatch:** same table, store 0x12C→... instead store 00000005 to 228 → `fail_cnt`=1, `pass_cnt`=8, `first_fail_addr`=228, `first_fail_data`=5, `pass`=0.
- **Illegal addresses:** stores to 236, 198 and 202 before the valid ones → `fail_cnt`=3, `first_fail_addr`=236; all 9 valid stores still count, so `done`=1 and `pass`=0.
- **Duplicate and timeout:** store 300 to 200 twice and no other stores → `pass_cnt`=1, `fail_cnt`=1; after 64 RUN cycles, `timeout`=1, `done`=1, `pass`=0.
- **Reset mid-run:** assert `rst_n`=0 after 4 stores → all outputs 0 and state IDLE; reload the table, `start` again, and the all-match sequence gives `pass`=1.
- **Ignored inputs:** `memwrite` pulses in IDLE and after DONE, plus `start` during RUN → no counter change and the run is not restarted.
